regfile_dbg_port: RTL and testbench
===================================

Name: regfile_dbg_port

Overview:
Debug and bring-up access engine for the processor register file. It sits beside the core and drives the register file's read and write ports while the core is stalled. Dump mode reads x0..x31 and streams them out over a valid/ready interface. Load mode accepts a valid/ready word stream and writes it into x1..x31. It replaces file-based register-file snapshot and preload in simulation with a synthesizable path.

Parameters:
NUM_REGS, 32, number of architectural registers scanned.
ADDR_W, 5, register address width; must equal clog2(NUM_REGS).
DATA_W, 32, register data width.

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_ni  input  1  reset, asynchronous, active-low
start_i  input  1  start request; sampled only in IDLE
mode_i  input  1  0 = dump, 1 = load; sampled with start_i
abort_i  input  1  cancel the current operation; returns to IDLE with no done pulse
busy_o  output  1  high in every state except IDLE; core stalls and must not write the register file
done_o  output  1  one-cycle pulse on successful completion
rf_raddr_o  output  ADDR_W  register file read address (read data is combinational)
rf_rdata_i  input  DATA_W  register file read data for rf_raddr_o
rf_waddr_o  output  ADDR_W  register file write address
rf_wdata_o  output  DATA_W  register file write data
rf_wren_o  output  1  register file write enable
dump_valid_o  output  1  dump word available
dump_ready_i  input  1  dump consumer accepts the word
dump_addr_o  output  ADDR_W  register index of dump_data_o
dump_data_o  output  DATA_W  dumped register value
load_valid_i  input  1  load word available
load_ready_o  output  1  block accepts the load word
load_data_i  input  DATA_W  load word

Behaviour:
- Reset (async, rst_ni=0): state=IDLE, counter=0. All outputs are 0, including busy_o, done_o, rf_wren_o, dump_valid_o and load_ready_o. Reset mid-operation drops any pending word and issues no write.
- States: IDLE, DUMP_RD, DUMP_OUT, LOAD, DONE.
- IDLE:
  - start_i=1 and mode_i=0: go to DUMP_RD, counter=0.
  - start_i=1 and mode_i=1: go to LOAD, counter=1.
  - start_i is ignored in every other state.
- DUMP_RD:
  - rf_raddr_o=counter.
  - At the clock edge, capture rf_rdata_i into dump_data_o and counter into dump_addr_o, then go to DUMP_OUT.
- DUMP_OUT:
  - dump_valid_o=1. dump_data_o and dump_addr_o stay stable until dump_ready_i=1.
  - On handshake with counter==NUM_REGS-1: go to DONE.
  - On handshake otherwise: counter+1, go to DUMP_RD.
  - A full dump takes 2 cycles per word when dump_ready_i is held high.
- LOAD:
  - load_ready_o=1.
  - On handshake, register the outputs so that on the next cycle rf_wren_o=1, rf_waddr_o=counter and rf_wdata_o=load_data_i. rf_wren_o lasts exactly one cycle per handshake.
  - With load_valid_i held high, one word is accepted per cycle (back-to-back).
  - On handshake with counter==NUM_REGS-1: go to DONE. The final write is presented during the DONE cycle.
  - x0 is never written.
- DONE: done_o=1 for one cycle, then go to IDLE. busy_o is still 1 in DONE.
- rf_raddr_o holds counter in every state.
- abort_i:
  - Takes priority over every transition and over start_i.
  - In any non-IDLE state, the next state is IDLE with no done pulse and dump_valid_o dropped.
  - A write already registered from a LOAD handshake in the abort cycle still occurs.
- Counter never wraps. A LOAD handshake is never accepted in DONE.

Test Plan:
1. Preload register file xi=0xA000_0000+i; dump with dump_ready_i=1 -> 32 words, addr 0..31, data matches; done_o pulses once, 65 cycles after start; busy_o high throughout.
2. Dump with dump_ready_i low for 5 cycles while word x3 is presented -> dump_valid_o, addr=3 and data stay stable; no word skipped or duplicated.
3. Load with load_valid_i=1 and data 0x1000+k for k=1..31 -> 31 back-to-back accepted words; rf_wren_o writes x1..x31 one cycle after each handshake; rf_waddr_o never 0; done_o pulses once.
4. Load with load_valid_i toggling every other cycle -> writes occur only after handshakes; final register x31=0x101F.
5. start_i pulsed mid-dump with mode_i=1 -> ignored, dump completes normally; abort_i at word 10 -> IDLE next cycle, no done_o, busy_o=0.
6. Assert rst_ni=0 asynchronously mid-load between clock edges -> all outputs 0 immediately; no further rf_wren_o; a new start after release works.

Source files
------------

// File: rtl/regfile_dbg_port.sv
// Register-file debug engine: streams x0..x31 out (dump) or writes a word stream
// into x1..x31 (load) while the core is stalled.
module regfile_dbg_port #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] rf_raddr_o,
    input  logic [DATA_W-1:0] rf_rdata_i,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic              rf_wren_o,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [ADDR_W-1:0] dump_addr_o,
    output logic [DATA_W-1:0] dump_data_o,
    input  logic              load_valid_i,
    output logic              load_ready_o,
    input  logic [DATA_W-1:0] load_data_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DUMP_RD,
        S_DUMP_OUT,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   dump_addr_q, dump_addr_d;
    logic [DATA_W-1:0]   dump_data_q, dump_data_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                load_hs;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dump_addr_q <= '0;
            dump_data_q <= '0;
            wren_q      <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dump_addr_q <= dump_addr_d;
            dump_data_q <= dump_data_d;
            wren_q      <= wren_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    // A load word accepted in the abort cycle is still written on the next cycle.
    assign load_hs = (state_q == S_LOAD) && load_valid_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dump_addr_d = dump_addr_q;
        dump_data_d = dump_data_q;
        wren_d      = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;

        if (load_hs) begin
            wren_d  = 1'b1;
            waddr_d = cnt_q;
            wdata_d = load_data_i;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (mode_i) begin
                        state_d = S_LOAD;
                        cnt_d   = ADDR_W'(1);
                    end else begin
                        state_d = S_DUMP_RD;
                        cnt_d   = '0;
                    end
                end
            end
            S_DUMP_RD: begin
                dump_data_d = rf_rdata_i;
                dump_addr_d = cnt_q;
                state_d     = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (dump_ready_i) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                        state_d = S_DUMP_RD;
                    end
                end
            end
            S_LOAD: begin
                if (load_valid_i) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every transition, including a start request in IDLE.
        if (abort_i) begin
            state_d = S_IDLE;
            cnt_d   = cnt_q;
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign rf_raddr_o   = cnt_q;
    assign rf_waddr_o   = waddr_q;
    assign rf_wdata_o   = wdata_q;
    assign rf_wren_o    = wren_q;
    assign dump_valid_o = (state_q == S_DUMP_OUT);
    assign dump_addr_o  = dump_addr_q;
    assign dump_data_o  = dump_data_q;
    assign load_ready_o = (state_q == S_LOAD);

endmodule

// File: tb/tb_regfile_dbg_port.sv
// Bench for regfile_dbg_port: a register-file model plus an array reference of
// its expected contents, exercised with randomized ready/valid/data patterns.
module tb_regfile_dbg_port;

    logic        clk_i;
    logic        rst_ni;
    logic        start_i;
    logic        mode_i;
    logic        abort_i;
    logic        busy_o;
    logic        done_o;
    logic [4:0]  rf_raddr_o;
    logic [31:0] rf_rdata_i;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        rf_wren_o;
    logic        dump_valid_o;
    logic        dump_ready_i;
    logic [4:0]  dump_addr_o;
    logic [31:0] dump_data_o;
    logic        load_valid_i;
    logic        load_ready_o;
    logic [31:0] load_data_i;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rf       [32];
    logic [31:0] exp_rf   [32];
    logic [31:0] pre_vals [32];
    logic        pre_we;

    regfile_dbg_port #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .abort_i      (abort_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .rf_raddr_o   (rf_raddr_o),
        .rf_rdata_i   (rf_rdata_i),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .rf_wren_o    (rf_wren_o),
        .dump_valid_o (dump_valid_o),
        .dump_ready_i (dump_ready_i),
        .dump_addr_o  (dump_addr_o),
        .dump_data_o  (dump_data_o),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .load_data_i  (load_data_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Register file model: combinational read, write on the rising edge.
    assign rf_rdata_i = rf[rf_raddr_o];
    always @(posedge clk_i) begin
        if (pre_we) begin
            for (int i = 0; i < 32; i++) rf[i] <= pre_vals[i];
        end else if (rf_wren_o) begin
            rf[rf_waddr_o] <= rf_wdata_o;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic preload(input bit rnd);
        for (int i = 0; i < 32; i++) begin
            pre_vals[i] = rnd ? $urandom : (32'hA000_0000 + 32'(i));
            exp_rf[i]   = pre_vals[i];
        end
        pre_we = 1'b1;
        tick();
        pre_we = 1'b0;
    endtask

    // Dump run; words are expected in order 0..31, each shown one cycle after
    // the previous handshake. Optional stall, stray start and abort points.
    task automatic drive_dump(input int rmode, input int stall_at, input int start_at,
                              input int abort_at, output int cyc_out);
        int n = 0;
        int cyc;
        int stall = 0;
        bit pres = 1'b0;
        bit fin = 1'b0;
        bit hs;
        start_i = 1'b1;
        mode_i  = 1'b0;
        tick();
        start_i = 1'b0;
        cyc = 1;
        while (1) begin
            if (cyc > 300) begin
                checks++; failures++;
                $display("FAIL dump_timeout: words=%0d after %0d cycles, required 32", n, cyc);
                break;
            end
            checks++;
            if (done_o !== fin) begin
                failures++;
                $display("FAIL dump_done: cycle %0d done_o=%b required %b", cyc, done_o, fin);
            end
            if (fin) break;
            checks++;
            if (busy_o !== 1'b1) begin
                failures++;
                $display("FAIL dump_busy: cycle %0d busy_o=%b required 1", cyc, busy_o);
            end
            checks++;
            if (dump_valid_o !== pres) begin
                failures++;
                $display("FAIL dump_valid: cycle %0d dump_valid_o=%b required %b", cyc, dump_valid_o, pres);
            end
            if (pres) begin
                checks++;
                if (dump_addr_o !== 5'(n) || dump_data_o !== exp_rf[n]) begin
                    failures++;
                    $display("FAIL dump_word: addr=%0d data=%h required addr=%0d data=%h",
                             dump_addr_o, dump_data_o, n, exp_rf[n]);
                end
            end
            dump_ready_i = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (pres && n == stall_at && stall < 5) begin
                dump_ready_i = 1'b0;
                stall++;
            end
            start_i = pres && (n == start_at);
            mode_i  = 1'b1;
            if (pres && n == abort_at) begin
                abort_i = 1'b1;
                tick();
                abort_i = 1'b0;
                start_i = 1'b0;
                checks++;
                if ({busy_o, done_o, dump_valid_o} !== 3'b000) begin
                    failures++;
                    $display("FAIL abort_idle: busy/done/valid=%b required 000",
                             {busy_o, done_o, dump_valid_o});
                end
                for (int k = 0; k < 5; k++) begin
                    tick();
                    checks++;
                    if ({busy_o, done_o} !== 2'b00) begin
                        failures++;
                        $display("FAIL abort_quiet: busy/done=%b required 00", {busy_o, done_o});
                    end
                end
                dump_ready_i = 1'b0;
                mode_i = 1'b0;
                cyc_out = cyc;
                return;
            end
            hs = pres && dump_ready_i;
            if (hs) begin
                if (n == 31) fin = 1'b1;
                n++;
                pres = 1'b0;
            end else begin
                pres = 1'b1;
            end
            tick();
            cyc++;
        end
        start_i = 1'b0;
        mode_i = 1'b0;
        dump_ready_i = 1'b0;
        tick();
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL dump_idle: busy=%b done=%b required 0 0", busy_o, done_o);
        end
        cyc_out = cyc;
    endtask

    // Load run; the k-th accepted word must be written to x(k) the cycle after.
    // vmode: 0 valid held high, 1 toggling, 2 random valid with random data.
    task automatic drive_load(input int vmode, output int cyc_out);
        int acc = 0;
        int cyc;
        bit pend = 1'b0;
        bit fin = 1'b0;
        bit ph;
        bit hs;
        logic [4:0]  paddr = '0;
        logic [31:0] pdata = '0;
        logic [31:0] d;
        ph = 1'($urandom_range(0, 1));
        start_i = 1'b1;
        mode_i  = 1'b1;
        tick();
        start_i = 1'b0;
        mode_i  = 1'b0;
        cyc = 1;
        while (1) begin
            if (cyc > 300) begin
                checks++; failures++;
                $display("FAIL load_timeout: accepted=%0d after %0d cycles, required 31", acc, cyc);
                break;
            end
            checks++;
            if (rf_wren_o !== pend) begin
                failures++;
                $display("FAIL load_wren: cycle %0d rf_wren_o=%b required %b", cyc, rf_wren_o, pend);
            end
            if (pend) begin
                checks++;
                if (rf_waddr_o !== paddr || rf_wdata_o !== pdata) begin
                    failures++;
                    $display("FAIL load_write: addr=%0d data=%h required addr=%0d data=%h",
                             rf_waddr_o, rf_wdata_o, paddr, pdata);
                end
            end
            checks++;
            if (rf_wren_o === 1'b1 && rf_waddr_o === 5'd0) begin
                failures++;
                $display("FAIL load_x0: write to x0 data=%h, required no write", rf_wdata_o);
            end
            checks++;
            if (done_o !== fin) begin
                failures++;
                $display("FAIL load_done: cycle %0d done_o=%b required %b", cyc, done_o, fin);
            end
            checks++;
            if (busy_o !== 1'b1 || load_ready_o !== (acc < 31)) begin
                failures++;
                $display("FAIL load_ready: busy=%b ready=%b required 1 %b", busy_o, load_ready_o, acc < 31);
            end
            if (fin) break;
            case (vmode)
                0:       load_valid_i = 1'b1;
                1:       load_valid_i = 1'(cyc) ^ ph;
                default: load_valid_i = 1'($urandom_range(0, 1));
            endcase
            d = (vmode == 2) ? $urandom : (32'h1000 + 32'(acc + 1));
            load_data_i = d;
            hs = load_valid_i && (acc < 31);
            pend = hs;
            if (hs) begin
                paddr = 5'(acc + 1);
                pdata = d;
                exp_rf[acc + 1] = d;
                acc++;
                if (acc == 31) fin = 1'b1;
            end
            tick();
            cyc++;
        end
        load_valid_i = 1'b1;
        tick();
        checks++;
        if ({busy_o, rf_wren_o, load_ready_o} !== 3'b000) begin
            failures++;
            $display("FAIL load_idle: busy/wren/ready=%b required 000", {busy_o, rf_wren_o, load_ready_o});
        end
        load_valid_i = 1'b0;
        cyc_out = cyc;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy_o, done_o, rf_wren_o, dump_valid_o, load_ready_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: busy/done/wren/valid/ready=%b required 00000",
                     {busy_o, done_o, rf_wren_o, dump_valid_o, load_ready_o});
        end
        checks++;
        if ({rf_raddr_o, rf_waddr_o, dump_addr_o} !== 15'b0 || {rf_wdata_o, dump_data_o} !== 64'b0) begin
            failures++;
            $display("FAIL reset_data: raddr=%0d waddr=%0d daddr=%0d wdata=%h ddata=%h required 0",
                     rf_raddr_o, rf_waddr_o, dump_addr_o, rf_wdata_o, dump_data_o);
        end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_dump_full();
        int cyc;
        preload(1'b0);
        drive_dump(0, -1, -1, -1, cyc);
        checks++;
        if (cyc != 65) begin
            failures++;
            $display("FAIL dump_latency: done after %0d cycles, required 65", cyc);
        end
    endtask

    task automatic test_dump_backpressure();
        int cyc;
        preload(1'b1);
        drive_dump(1, 3, -1, -1, cyc);
    endtask

    task automatic test_dump_start_ignored();
        int cyc;
        preload(1'b1);
        drive_dump(0, -1, 5, -1, cyc);
        checks++;
        if (cyc != 65) begin
            failures++;
            $display("FAIL start_ignored: done after %0d cycles, required 65", cyc);
        end
    endtask

    task automatic test_dump_abort();
        int cyc;
        drive_dump(1, -1, -1, 10, cyc);
    endtask

    task automatic test_load_b2b();
        int cyc;
        drive_load(0, cyc);
        checks++;
        if (cyc != 32) begin
            failures++;
            $display("FAIL load_b2b_latency: done after %0d cycles, required 32", cyc);
        end
    endtask

    task automatic test_load_toggle();
        int cyc;
        drive_load(1, cyc);
        checks++;
        if (rf[31] !== 32'h0000_101F) begin
            failures++;
            $display("FAIL load_toggle_x31: x31=%h required 0000101f", rf[31]);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (rf[i] !== exp_rf[i]) begin
                failures++;
                $display("FAIL load_toggle_rf: x%0d=%h required %h", i, rf[i], exp_rf[i]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        start_i = 1'b1;
        mode_i  = 1'b1;
        tick();
        start_i = 1'b0;
        mode_i  = 1'b0;
        load_valid_i = 1'b1;
        load_data_i  = $urandom;
        tick();
        tick();
        tick();
        checks++;
        if (rf_wren_o !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_wren: rf_wren_o=%b required 1", rf_wren_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, rf_wren_o, dump_valid_o, load_ready_o} !== 5'b0 ||
            {rf_raddr_o, rf_waddr_o, dump_addr_o} !== 15'b0 || {rf_wdata_o, dump_data_o} !== 64'b0) begin
            failures++;
            $display("FAIL async_reset: ctrl=%b raddr=%0d waddr=%0d wdata=%h required all 0",
                     {busy_o, done_o, rf_wren_o, dump_valid_o, load_ready_o},
                     rf_raddr_o, rf_waddr_o, rf_wdata_o);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({busy_o, rf_wren_o, load_ready_o} !== 3'b000) begin
                failures++;
                $display("FAIL reset_hold: busy/wren/ready=%b required 000", {busy_o, rf_wren_o, load_ready_o});
            end
        end
        load_valid_i = 1'b0;
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_load_random();
        int cyc;
        drive_load(2, cyc);
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (rf[i] !== exp_rf[i]) begin
                failures++;
                $display("FAIL load_random_rf: x%0d=%h required %h", i, rf[i], exp_rf[i]);
            end
        end
    endtask

    initial begin
        rst_ni       = 1'b0;
        start_i      = 1'b0;
        mode_i       = 1'b0;
        abort_i      = 1'b0;
        dump_ready_i = 1'b0;
        load_valid_i = 1'b0;
        load_data_i  = '0;
        pre_we       = 1'b0;
        for (int i = 0; i < 32; i++) pre_vals[i] = '0;
        test_reset();
        test_dump_full();
        test_dump_backpressure();
        test_dump_start_ignored();
        test_dump_abort();
        test_load_b2b();
        test_load_toggle();
        test_reset_mid_load();
        test_load_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
